// File: rtl/stepper4pin_monitor.sv
// stepper4pin_monitor: synchronises and filters 4-wire stepper phase pins, decodes the
// 8-phase half-step sequence and tracks position, direction, step period and errors.
module stepper4pin_monitor #(
  parameter int FILTER   = 2,
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear,
  input  logic                a1,
  input  logic                a2,
  input  logic                b1,
  input  logic                b2,
  output logic signed [31:0]  position,
  output logic                direction,
  output logic                step_pulse,
  output logic [PERIOD_W-1:0] step_period,
  output logic                idle,
  output logic                error_pulse,
  output logic [15:0]         error_count
);
  // state    | meaning
  // UNSEEDED | no trusted phase; the next valid pattern only seeds it
  // SEEDED   | phase holds the last accepted valid phase
  typedef enum logic {UNSEEDED, SEEDED} state_t;

  localparam int CW = $clog2(FILTER + 2);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] PMAX = '1;
  localparam logic [PERIOD_W-1:0] PONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

  logic [3:0]          sync1, sync2, cand, filt;
  logic [CW-1:0]       stable_cnt;
  logic [2:0]          phase, new_phase, d;
  logic                new_valid, accept, load, step, err;
  logic signed [3:0]   delta;
  logic signed [31:0]  delta_ext;
  logic [PERIOD_W-1:0] period_cnt;
  state_t              state, state_nxt;

  generate
    if (FILTER == 0) begin : g_nofilt
      assign accept = 1'b1;
    end else begin : g_filt
      localparam logic [CW-1:0] FLIM = CW'(FILTER - 1);
      assign accept = (sync2 == cand) && (stable_cnt >= FLIM);
    end
  endgenerate

  always_comb begin
    new_valid = 1'b1;
    new_phase = 3'd0;
    case (sync2)
      4'b1000: new_phase = 3'd0;
      4'b1100: new_phase = 3'd1;
      4'b0100: new_phase = 3'd2;
      4'b0110: new_phase = 3'd3;
      4'b0010: new_phase = 3'd4;
      4'b0011: new_phase = 3'd5;
      4'b0001: new_phase = 3'd6;
      4'b1001: new_phase = 3'd7;
      default: new_valid = 1'b0;
    endcase
  end

  assign d         = new_phase - phase;
  assign delta_ext = {{28{delta[3]}}, delta};
  assign idle      = (filt == 4'b0000);

  // An unseeded decoder also reacts to an unchanged valid pattern so that
  // re-enabling on a steady phase seeds without waiting for the next step.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    err       = 1'b0;
    delta     = '0;
    if (!enable) begin
      state_nxt = UNSEEDED;
    end else if (accept && ((sync2 != filt) || (state == UNSEEDED && new_valid))) begin
      if (sync2 == 4'b0000) begin
        state_nxt = UNSEEDED;
      end else if (!new_valid) begin
        err = (sync2 != filt);
      end else if (state == UNSEEDED) begin
        state_nxt = SEEDED;
        load      = 1'b1;
      end else if (d == 3'd4) begin
        err  = 1'b1;
        load = 1'b1;
      end else if (d != 3'd0) begin
        step  = 1'b1;
        load  = 1'b1;
        delta = {d[2], d};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      cand        <= '0;
      filt        <= '0;
      stable_cnt  <= '0;
      state       <= UNSEEDED;
      phase       <= '0;
      position    <= '0;
      direction   <= 1'b0;
      step_pulse  <= 1'b0;
      error_pulse <= 1'b0;
      error_count <= '0;
      step_period <= PMAX;
      period_cnt  <= '0;
    end else begin
      sync1 <= {b2, b1, a2, a1};
      sync2 <= sync1;
      cand  <= sync2;
      if (sync2 != cand) stable_cnt <= '0;
      else if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + 1'b1;
      if (accept) filt <= sync2;
      state <= state_nxt;
      if (load) phase <= new_phase;
      step_pulse  <= step;
      error_pulse <= err;
      if (step) direction <= ~delta[3];
      if (clear) position <= step ? delta_ext : '0;
      else if (step) position <= position + delta_ext;
      if (clear) error_count <= {15'd0, err};
      else if (err && error_count != 16'hFFFF) error_count <= error_count + 16'd1;
      if (step) begin
        step_period <= (period_cnt == PMAX) ? PMAX : period_cnt + PONE;
        period_cnt  <= '0;
      end else if (period_cnt != PMAX) begin
        period_cnt <= period_cnt + PONE;
      end
    end
  end
endmodule

// File: tb/tb_stepper4pin_monitor.sv
// Scoreboard bench for stepper4pin_monitor: directed pin sequences push expected step/error
// events; a negedge monitor pops and compares them whenever a pulse appears.
module tb_stepper4pin_monitor;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1, clear = 1'b0;
  logic [3:0] pins = 4'b0000;
  logic signed [31:0] position;
  logic direction, step_pulse, idle, error_pulse;
  logic [31:0] step_period;
  logic [15:0] error_count;

  logic enable2 = 1'b1, clear2 = 1'b0;
  logic [3:0] pins2 = 4'b0000;
  logic signed [31:0] position2;
  logic direction2, step_pulse2, idle2, error_pulse2;
  logic [31:0] step_period2;
  logic [15:0] error_count2;

  stepper4pin_monitor #(.FILTER(2), .PERIOD_W(32)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .a1(pins[0]), .a2(pins[1]), .b1(pins[2]), .b2(pins[3]),
    .position(position), .direction(direction), .step_pulse(step_pulse),
    .step_period(step_period), .idle(idle), .error_pulse(error_pulse),
    .error_count(error_count));

  stepper4pin_monitor #(.FILTER(0), .PERIOD_W(32)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable2), .clear(clear2),
    .a1(pins2[0]), .a2(pins2[1]), .b1(pins2[2]), .b2(pins2[3]),
    .position(position2), .direction(direction2), .step_pulse(step_pulse2),
    .step_period(step_period2), .idle(idle2), .error_pulse(error_pulse2),
    .error_count(error_count2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int chg_cyc = 0;

  typedef struct {
    bit err;
    int pos;
    bit dir;
    int errc;
    bit chkp;
    int per;
    int cyc;
  } ev_t;
  ev_t sb[$];
  ev_t mon_e;

  logic [3:0] ph [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                         4'b0010, 4'b0011, 4'b0001, 4'b1001};
  logic [3:0] rev [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pins(input logic [3:0] p);
    pins = p;
    chg_cyc = cyc;
  endtask

  task automatic push_step(input int pos, input bit dir, input bit chkp, input int per);
    sb.push_back('{1'b0, pos, dir, 0, chkp, per, chg_cyc + 5});
  endtask

  task automatic push_err(input int pos, input int errc);
    sb.push_back('{1'b1, pos, 1'b0, errc, 1'b0, 0, chg_cyc + 5});
  endtask

  always @(negedge clk) begin
    if (!rst && (step_pulse || error_pulse)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event step=%0b err=%0b pos=%0d cycle=%0d",
                 step_pulse, error_pulse, position, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("ev_kind", longint'(error_pulse), longint'(mon_e.err));
        chk("ev_cycle", longint'(cyc), longint'(mon_e.cyc));
        chk("ev_position", longint'(position), longint'(mon_e.pos));
        if (mon_e.err) begin
          chk("ev_error_count", longint'(error_count), longint'(mon_e.errc));
        end else begin
          chk("ev_direction", longint'(direction), longint'(mon_e.dir));
          if (mon_e.chkp) chk("ev_step_period", longint'(step_period), longint'(mon_e.per));
        end
      end
    end
  end

  initial begin
    #3000000;
    failures++;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    wait_n(3);
    rst = 1'b0;
    chk("rst_position", longint'(position), 0);
    chk("rst_direction", longint'(direction), 0);
    chk("rst_step_pulse", longint'(step_pulse), 0);
    chk("rst_step_period", longint'(step_period), 64'hFFFFFFFF);
    chk("rst_idle", longint'(idle), 1);
    chk("rst_error_pulse", longint'(error_pulse), 0);
    chk("rst_error_count", longint'(error_count), 0);
    wait_n(5);

    // half-step forward
    set_pins(ph[0]);
    wait_n(100);
    for (int k = 1; k <= 8; k++) begin
      set_pins(ph[k % 8]);
      push_step(k, 1'b1, k >= 2, 100);
      wait_n(100);
    end
    chk("fwd_position", longint'(position), 8);
    chk("fwd_direction", longint'(direction), 1);
    chk("fwd_step_period", longint'(step_period), 100);
    chk("fwd_drained", longint'(sb.size()), 0);

    // clear, idle, full-step reverse
    clear = 1'b1;
    wait_n(1);
    clear = 1'b0;
    chk("clear_position", longint'(position), 0);
    set_pins(4'b0000);
    wait_n(10);
    chk("idle_on", longint'(idle), 1);
    set_pins(4'b1001);
    wait_n(20);
    chk("idle_off", longint'(idle), 0);
    chk("seed_no_count", longint'(position), 0);
    for (int i = 0; i < 4; i++) begin
      set_pins(rev[i]);
      push_step(-2 * (i + 1), 1'b0, i >= 1, 20);
      wait_n(20);
    end
    chk("rev_position", longint'(position), -8);
    chk("rev_direction", longint'(direction), 0);

    // glitch rejection
    set_pins(ph[0]);
    push_step(-7, 1'b1, 1'b1, 20);
    wait_n(20);
    pins = 4'b1100;
    wait_n(1);
    pins = ph[0];
    wait_n(20);
    chk("glitch_position", longint'(position), -7);
    chk("glitch_period", longint'(step_period), 20);

    // illegal pattern and ambiguous jump
    set_pins(4'b1111);
    push_err(-7, 1);
    wait_n(20);
    set_pins(ph[0]);
    wait_n(20);
    set_pins(ph[4]);
    push_err(-7, 2);
    wait_n(20);
    set_pins(ph[5]);
    push_step(-6, 1'b1, 1'b0, 0);
    wait_n(20);
    chk("err_count_two", longint'(error_count), 2);

    // idle reseed and enable gating
    set_pins(4'b0000);
    wait_n(10);
    chk("idle_again", longint'(idle), 1);
    set_pins(ph[2]);
    wait_n(20);
    chk("reseed_position", longint'(position), -6);
    set_pins(ph[3]);
    push_step(-5, 1'b1, 1'b0, 0);
    wait_n(20);
    enable = 1'b0;
    set_pins(ph[4]);
    wait_n(20);
    set_pins(ph[5]);
    wait_n(20);
    set_pins(4'b1111);
    wait_n(20);
    set_pins(ph[6]);
    wait_n(20);
    chk("disabled_position", longint'(position), -5);
    chk("disabled_errors", longint'(error_count), 2);
    enable = 1'b1;
    wait_n(20);
    set_pins(ph[7]);
    push_step(-4, 1'b1, 1'b0, 0);
    wait_n(20);

    // clear to zero then count to 57, then clear coincident with a step
    clear = 1'b1;
    wait_n(1);
    clear = 1'b0;
    chk("clear_error_count", longint'(error_count), 0);
    chk("clear_position2", longint'(position), 0);
    for (int k = 1; k <= 57; k++) begin
      set_pins(ph[(7 + k) % 8]);
      push_step(k, 1'b1, k >= 2, 6);
      wait_n(6);
    end
    chk("pos_57", longint'(position), 57);
    set_pins(ph[1]);
    push_step(1, 1'b1, 1'b1, 6);
    wait_n(4);
    clear = 1'b1;
    wait_n(1);
    clear = 1'b0;
    wait_n(10);
    chk("clear_with_step", longint'(position), 1);

    // asynchronous reset mid-run
    wait_n(5);
    #2 rst = 1'b1;
    #1;
    chk("arst_position", longint'(position), 0);
    chk("arst_direction", longint'(direction), 0);
    chk("arst_step_pulse", longint'(step_pulse), 0);
    chk("arst_step_period", longint'(step_period), 64'hFFFFFFFF);
    chk("arst_idle", longint'(idle), 1);
    chk("arst_error_pulse", longint'(error_pulse), 0);
    chk("arst_error_count", longint'(error_count), 0);
    wait_n(1);
    rst = 1'b0;
    wait_n(20);
    chk("post_rst_seed", longint'(position), 0);
    set_pins(ph[2]);
    push_step(1, 1'b1, 1'b0, 0);
    wait_n(20);
    chk("post_rst_position", longint'(position), 1);
    chk("final_drained", longint'(sb.size()), 0);

    // error_count saturation on the unfiltered instance
    chk("sat_start", longint'(error_count2), 0);
    for (int i = 0; i < 65600; i++) begin
      pins2 = i[0] ? 4'b1110 : 4'b1111;
      @(negedge clk);
    end
    wait_n(5);
    chk("sat_error_count", longint'(error_count2), 65535);
    chk("sat_position", longint'(position2), 0);
    clear2 = 1'b1;
    wait_n(1);
    clear2 = 1'b0;
    chk("sat_clear", longint'(error_count2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
